// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals shared between the ALU arbiter and its requesters.
// slave is the arbiter's view; master is the requesters' and the ALU's view.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_wflags;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_wflags;

  logic [3:0]  alu_op;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_out;
  logic        alu_n;
  logic        alu_v;
  logic        alu_z;
  logic [2:0]  alu_flag_en;

  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [15:0] rsp_data;
  logic [2:0]  flags;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_wflags,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, req1_wflags,
    output req1_ready,
    output alu_op, alu_in1, alu_in2,
    input  alu_out, alu_n, alu_v, alu_z, alu_flag_en,
    output rsp0_valid, rsp1_valid, rsp_data, flags
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_wflags,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, req1_wflags,
    input  req1_ready,
    input  alu_op, alu_in1, alu_in2,
    output alu_out, alu_n, alu_v, alu_z, alu_flag_en,
    input  rsp0_valid, rsp1_valid, rsp_data, flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two ports; response strobe 2 cycles after acceptance.
// One op in flight, new acceptance allowed in the response cycle; responses are not backpressured.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_id;
  logic        r_wflags;
  logic [3:0]  r_alu_op;
  logic [15:0] r_alu_in1;
  logic [15:0] r_alu_in2;
  logic [15:0] r_rsp_data;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [2:0]  r_flags;

  logic        w_open;
  logic        w_grant;
  logic        w_accept;
  logic [2:0]  w_alu_flags;
  logic [2:0]  w_flags_nxt;

  assign w_open = (r_state == S_IDLE) || (r_state == S_RESP);

  // A tie goes to the port that did not win last time.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (bus.req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign bus.req0_ready = w_open && !w_grant;
  assign bus.req1_ready = w_open && w_grant;
  assign w_accept       = w_open && (bus.req0_valid || bus.req1_valid);

  assign w_alu_flags = {bus.alu_n, bus.alu_v, bus.alu_z};
  assign w_flags_nxt = (w_alu_flags & bus.alu_flag_en) | (r_flags & ~bus.alu_flag_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_wflags     <= 1'b0;
      r_alu_op     <= 4'h0;
      r_alu_in1    <= 16'h0000;
      r_alu_in2    <= 16'h0000;
      r_rsp_data   <= 16'h0000;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_flags      <= 3'b000;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        S_EXEC: begin
          r_rsp_data <= bus.alu_out;
          if (r_wflags) begin
            r_flags <= w_flags_nxt;
          end
          r_rsp0_valid <= !r_id;
          r_rsp1_valid <= r_id;
          r_state      <= S_RESP;
        end
        default: begin
          if (w_accept) begin
            r_alu_op     <= w_grant ? bus.req1_op     : bus.req0_op;
            r_alu_in1    <= w_grant ? bus.req1_a      : bus.req0_a;
            r_alu_in2    <= w_grant ? bus.req1_b      : bus.req0_b;
            r_wflags     <= w_grant ? bus.req1_wflags : bus.req0_wflags;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_EXEC;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.alu_op     = r_alu_op;
  assign bus.alu_in1    = r_alu_in1;
  assign bus.alu_in2    = r_alu_in2;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.flags      = r_flags;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the auxiliary/debug engine. It grants one operation at a time with round-robin fairness and registers the ALU operands into the ALU. It captures the ALU result one cycle later and returns it on the granted port's response. It owns the architectural FLAG register ({N,V,Z}), updating only the bits the ALU enables and only for requests that ask for it.

## Interface
- No parameters. Data width is fixed at 16 and opcode width at 4.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  4  ALU opcode
- req0_a / req1_a  in  16  operand 1
- req0_b / req1_b  in  16  operand 2
- req0_wflags / req1_wflags  in  1  request may update FLAG register
- alu_op  out  4  registered opcode driven to ALU
- alu_in1 / alu_in2  out  16  registered operands driven to ALU
- alu_out  in  16  ALU result
- alu_n / alu_v / alu_z  in  1  ALU flag outputs
- alu_flag_en  in  3  ALU flag enables: [2]=N, [1]=V, [0]=Z
- rsp0_valid / rsp1_valid  out  1  one-cycle response strobe per port
- rsp_data  out  16  registered result, valid with either rsp strobe
- flags  out  3  FLAG register {N,V,Z}

## Operation
- States:
  - IDLE: no operation in flight.
  - EXEC: operands are on the ALU.
  - RESP: result is registered.
- Readiness and acceptance:
  - reqX_ready = (state==IDLE || state==RESP) && grant==X, combinational from the current valids.
  - Acceptance latches op, a, b, wflags and the port id into the alu_op/alu_in1/alu_in2 registers, then moves to EXEC.
- Arbitration:
  - If only one port is valid, that port is granted.
  - If both are valid, grant goes to the port not in last_grant.
  - last_grant updates on every acceptance and resets to 1, so port 0 wins the first tie.
- EXEC:
  - At the clock edge, alu_out is sampled into rsp_data.
  - If wflags=1, each flags bit i with alu_flag_en[i]=1 loads the matching ALU flag; bits whose enable is 0 hold.
  - If wflags=0, flags hold.
  - Next state is RESP.
- RESP:
  - rsp<id>_valid is high for exactly this cycle.
  - A new request may be accepted in the same cycle: next state is EXEC if accepted, else IDLE.
- Responses have no backpressure; the requester must sample rsp_data while its strobe is high.
- Requesters hold op, a, b and wflags stable while valid && !ready. The arbiter never drops a valid request.
- alu_op/alu_in1/alu_in2 hold their last values in IDLE; the ALU output is ignored outside EXEC.
- Opcodes with alu_flag_en=000 (RED, PADDSB, LW/SW address, undefined) never change flags, even with wflags=1.

## Timing
- Reset values:
  - state=IDLE, last_grant=1.
  - alu_op=0, alu_in1=0, alu_in2=0.
  - rsp_data=0, rsp0_valid=0, rsp1_valid=0.
  - flags=000.
- Latency: request accepted at edge T produces its response strobe in the cycle after edge T+1, i.e. 2 cycles after acceptance.
- Throughput: one operation per 2 cycles when requests are back-to-back (acceptance in RESP).
- Flags update at the same edge that loads rsp_data, so flags are new in the cycle the rsp strobe is high.
- Reset mid-operation: the in-flight operation is discarded, no response is issued and flags return to 000 immediately (asynchronous).
- Only one of rsp0_valid and rsp1_valid is ever high in a cycle; both are low in IDLE and EXEC.
- Fairness: a continuously valid port waits at most one operation of the other port.

## Test plan
- Reset then port-0 ADD, a=0x0003, b=0x0004, wflags=1 -> req0_ready in IDLE; rsp0_valid 2 cycles later with rsp_data=0x0007; flags=000.
- Port-0 ADD 0x7FFF+0x0001, wflags=1 -> rsp_data=0x7FFF (saturated); flags=010 (V=1).
- After flags=010, port-1 XOR 0x00FF^0x00FF, wflags=1 -> rsp1_valid with rsp_data=0x0000; flags=011 (Z set, V held, N unchanged).
- Both ports continuously valid with SUB ops for 6 grants -> grants alternate 0,1,0,1,0,1; one response every 2 cycles; no overlapping strobes.
- Port 1 SLL with wflags=0, result 0x0000 -> flags unchanged; RED with wflags=1 -> flags unchanged (flag_en=000).
- rst asserted during EXEC of a valid ADD -> no rsp strobe; flags=000; state IDLE; the next request is granted to port 0 on a tie.
